// File: rtl/synth_arith_pkg.sv
// Shared arithmetic definitions for the synth control-path divider.
package synth_arith_pkg;

   localparam int WIDTH_DEF = 18;
   localparam int CNT_W_DEF = 5;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [WIDTH_DEF-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division iteration: trial subtract, keep or restore, emit quotient bit.
module restoring_div_step #(
   parameter int WIDTH = 18
) (
   input  logic [WIDTH:0]   r,
   input  logic             q_msb,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH:0]   r_next,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;
   logic           unused_r_msb;

   // r never exceeds d between steps, so its top bit is always shifted out
   assign unused_r_msb = r[WIDTH];
   assign shifted      = {r[WIDTH-1:0], q_msb};
   assign trial        = shifted - {1'b0, d};
   assign q_bit        = ~trial[WIDTH];
   assign r_next       = q_bit ? trial : shifted;

endmodule

// File: rtl/eighteen_bit_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
module eighteen_bit_divider
   import synth_arith_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   state_t           state, state_nxt;
   logic [WIDTH:0]   r, r_nxt;
   logic [WIDTH-1:0] q, d, q_nxt;
   logic [CNT_W-1:0] count;
   logic             q_bit;
   logic             accept;

   assign accept = start && (state != RUN);
   assign q_nxt  = {q[WIDTH-2:0], q_bit};

   restoring_div_step #(.WIDTH(WIDTH)) u_step (
      .r      (r),
      .q_msb  (q[WIDTH-1]),
      .d      (d),
      .r_next (r_nxt),
      .q_bit  (q_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE, DONE: begin
            if (start)             state_nxt = (divisor == '0) ? DONE : RUN;
            else if (state == DONE) state_nxt = IDLE;
         end
         RUN:     if (count == '0) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r           <= '0;
         q           <= '0;
         d           <= '0;
         count       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            q           <= dividend;
            d           <= divisor;
            r           <= '0;
            count       <= CNT_W'(WIDTH - 1);
            div_by_zero <= 1'b0;
            // Zero divisor skips iteration and completes straight away
            if (divisor == '0) begin
               quotient    <= {WIDTH{1'b1}};
               remainder   <= dividend;
               div_by_zero <= 1'b1;
               done        <= 1'b1;
               busy        <= 1'b0;
            end else begin
               busy <= 1'b1;
            end
         end else if (state == RUN) begin
            r     <= r_nxt;
            q     <= q_nxt;
            count <= count - CNT_W'(1);
            if (count == '0) begin
               quotient  <= q_nxt;
               remainder <= r_nxt[WIDTH-1:0];
               busy      <= 1'b0;
               done      <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_eighteen_bit_divider.sv
// Directed and random checks of eighteen_bit_divider against a cycle-level arithmetic model.
module tb_eighteen_bit_divider;

   localparam int W = 18;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0, divisor = '0;
   logic [W-1:0] quotient, remainder;
   logic         busy, done, div_by_zero;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   eighteen_bit_divider dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // Model: accepted op completes W edges later (or on the accepting edge for /0)
   int           m_cnt = 0;
   logic         m_busy = 0, m_done = 0, m_dbz = 0;
   logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt <= 0; m_busy <= 0; m_done <= 0; m_dbz <= 0;
         m_q <= '0; m_r <= '0;
      end else begin
         m_done <= 0;
         if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               m_done <= 1; m_busy <= 0; m_q <= p_q; m_r <= p_r;
            end
         end else if (start) begin
            m_dbz <= 0;
            if (divisor == 0) begin
               m_done <= 1; m_q <= '1; m_r <= dividend; m_dbz <= 1;
            end else begin
               m_busy <= 1; m_cnt <= W;
               p_q <= dividend / divisor; p_r <= dividend % divisor;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("model_busy", busy, m_busy);
      check("model_done", done, m_done);
      check("model_dbz", div_by_zero, m_dbz);
      check("model_quot", quotient, m_q);
      check("model_rem", remainder, m_r);
   end

   task automatic wait_done(input string nm, output int n, output int nb);
      bit found = 0;
      n = 0; nb = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         n++;
         if (busy) nb++;
         if (done) found = 1;
      end
      if (!found) check({nm, "_timeout"}, 0, 1);
   endtask

   task automatic run_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
      int    n, nb;
      string tag;
      tag = $sformatf("op%0d_%0d/%0d", idx, a, b);
      @(posedge clk); #1;
      dividend = a; divisor = b; start = 1;
      @(posedge clk); #1;
      start = 0;
      wait_done(tag, n, nb);
      check({tag, "_lat"}, n, (b == 0) ? 1 : 19);
      check({tag, "_busycyc"}, nb, (b == 0) ? 0 : 18);
      check({tag, "_quot"}, quotient, eq);
      check({tag, "_rem"}, remainder, er);
      check({tag, "_dbz"}, div_by_zero, edbz);
      if (b != 0) begin
         check({tag, "_ident"}, 64'(quotient) * 64'(b) + 64'(remainder), 64'(a));
         check({tag, "_rem_lt"}, remainder < b, 1);
      end
   endtask

   initial begin
      int n, nb, last;
      logic [W-1:0] a, b;

      #2 rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_quot", quotient, 0);
      check("rst_rem", remainder, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst_n = 1;

      run_op(0, 100, 7, 14, 2, 0);
      run_op(1, 262143, 1, 262143, 0, 0);
      run_op(2, 3, 10, 0, 3, 0);
      run_op(3, 5, 0, 18'h3FFFF, 5, 1);

      // start during RUN with different operands must be ignored
      @(posedge clk); #1;
      dividend = 100; divisor = 7; start = 1;
      @(posedge clk); #1;
      start = 0;
      repeat (4) @(posedge clk);
      #1;
      dividend = 9; divisor = 3; start = 1;
      @(posedge clk); #1;
      start = 0; dividend = 0; divisor = 0;
      wait_done("ignored", n, nb);
      check("ignored_quot", quotient, 14);
      check("ignored_rem", remainder, 2);
      run_op(4, 9, 3, 3, 0, 0);

      // start held high: alternate 100/7 and 50000/123 back to back
      @(posedge clk); #1;
      dividend = 100; divisor = 7; start = 1;
      last = 0;
      for (int k = 0; k < 4; k++) begin
         wait_done($sformatf("b2b%0d", k), n, nb);
         check($sformatf("b2b%0d_quot", k), quotient, (k % 2 == 0) ? 14 : 406);
         check($sformatf("b2b%0d_rem", k), remainder, (k % 2 == 0) ? 2 : 62);
         if (k > 0) check($sformatf("b2b%0d_gap", k), cyc - last, 19);
         last = cyc;
         if (k % 2 == 0) begin dividend = 50000; divisor = 123; end
         else begin dividend = 100; divisor = 7; end
      end
      start = 0;

      // reset at RUN cycle 9 abandons the op
      @(posedge clk); #1;
      dividend = 1000; divisor = 33; start = 1;
      @(posedge clk); #1;
      start = 0;
      repeat (8) @(posedge clk);
      #2 rst_n = 0;
      #1;
      check("midrst_quot", quotient, 0);
      check("midrst_rem", remainder, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_dbz", div_by_zero, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      repeat (25) @(posedge clk);
      run_op(5, 1000, 33, 30, 10, 0);

      for (int i = 0; i < 300; i++) begin
         a = W'($urandom_range(0, 262143));
         if (i % 25 == 0)                 b = '0;
         else if ($urandom_range(0, 3) == 0) b = W'($urandom_range(1, 15));
         else                             b = W'($urandom_range(1, 262143));
         if (b == 0) run_op(100 + i, a, b, '1, a, 1);
         else        run_op(100 + i, a, b, a / b, a % b, 0);
      end

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
